// File: rtl/cipher_round_engine.sv
// Iterative byte-wise round engine: one round per cycle, valid/ready on both sides.
// Encrypt and decrypt share the datapath; the round counter runs up or down by mode.
module cipher_round_engine #(
    parameter int DATA_W = 32,
    parameter int ROUNDS = 4,
    parameter int ROT    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_mode,
    input  logic [DATA_W-1:0] key,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_mode,
    output logic              busy
);

    localparam int unsigned NB       = DATA_W / 8;
    localparam logic [7:0]  LAST_ENC = 8'(ROUNDS - 1);
    localparam logic [7:0]  WHITEN   = 8'h5A;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] work;
    logic [DATA_W-1:0] key_q;
    logic [DATA_W-1:0] round_out;
    logic              mode_q;
    logic [7:0]        ctr;
    logic              last_round;

    function automatic logic [7:0] rotl8(input logic [7:0] v);
        return 8'((v << ROT) | (v >> (8 - ROT)));
    endfunction

    function automatic logic [7:0] rotr8(input logic [7:0] v);
        return 8'((v >> ROT) | (v << (8 - ROT)));
    endfunction

    function automatic logic [7:0] round_byte(input logic [7:0] d, input logic [7:0] k,
                                              input logic [7:0] r, input logic dec);
        if (dec)
            return rotr8(d - WHITEN) ^ k ^ r;
        else
            return rotl8(d ^ k ^ r) + WHITEN;
    endfunction

    always_comb begin
        round_out = '0;
        for (int unsigned b = 0; b < NB; b++)
            round_out[8*b +: 8] = round_byte(work[8*b +: 8], key_q[8*b +: 8], ctr, mode_q);
    end

    // Decrypt walks the counter down, so its final round is the one at zero.
    assign last_round = mode_q ? (ctr == 8'd0) : (ctr == LAST_ENC);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid && rst_n)
                    state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_round)
                    state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work     <= '0;
            key_q    <= '0;
            mode_q   <= 1'b0;
            ctr      <= '0;
            out_data <= '0;
            out_mode <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work   <= in_data;
                        key_q  <= key;
                        mode_q <= in_mode;
                        ctr    <= in_mode ? LAST_ENC : 8'd0;
                    end
                end
                RUN: begin
                    work <= round_out;
                    ctr  <= mode_q ? ctr - 8'd1 : ctr + 8'd1;
                    // Result lands in a separate register so it survives the next accept.
                    if (last_round) begin
                        out_data <= round_out;
                        out_mode <= mode_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cipher_round_engine.sv
// Directed bench for cipher_round_engine: small hand-computed instances plus a
// default-parameter instance for round trips, backpressure, reset and throughput.
module tb_cipher_round_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       v8, m8, ordy8;
    logic [7:0] d8, k8;
    logic       r1_irdy, r1_ov, r1_om, r1_busy;
    logic [7:0] r1_od;
    logic       r2_irdy, r2_ov, r2_om, r2_busy;
    logic [7:0] r2_od;

    logic        v3, m3, ordy3;
    logic [31:0] d3, k3, od3;
    logic        ir3, ov3, om3, busy3;

    int n_checks = 0;
    int n_fail   = 0;

    cipher_round_engine #(.DATA_W(8), .ROUNDS(1), .ROT(3)) u_r1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r1_irdy), .in_data(d8),
        .in_mode(m8), .key(k8), .out_valid(r1_ov), .out_ready(ordy8), .out_data(r1_od),
        .out_mode(r1_om), .busy(r1_busy)
    );

    cipher_round_engine #(.DATA_W(8), .ROUNDS(2), .ROT(3)) u_r2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r2_irdy), .in_data(d8),
        .in_mode(m8), .key(k8), .out_valid(r2_ov), .out_ready(ordy8), .out_data(r2_od),
        .out_mode(r2_om), .busy(r2_busy)
    );

    cipher_round_engine #(.DATA_W(32), .ROUNDS(4), .ROT(3)) u_def (
        .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(ir3), .in_data(d3),
        .in_mode(m3), .key(k3), .out_valid(ov3), .out_ready(ordy3), .out_data(od3),
        .out_mode(om3), .busy(busy3)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_rotl3(input logic [7:0] v);
        logic [15:0] t;
        t = {v, v} << 3;
        return t[15:8];
    endfunction

    function automatic logic [31:0] model_enc(input logic [31:0] d, input logic [31:0] k);
        logic [31:0] x;
        x = d;
        for (int r = 0; r < 4; r++)
            for (int b = 0; b < 4; b++)
                x[8*b +: 8] = m_rotl3(x[8*b +: 8] ^ k[8*b +: 8] ^ 8'(r)) + 8'h5A;
        return x;
    endfunction

    // Latency counts edges from and including the accepting edge.
    task automatic xfer8(input logic [7:0] d, input logic [7:0] k, input logic m,
                         output logic [7:0] o1, output logic [7:0] o2,
                         output logic om1, output logic om2, output int l1, output int l2);
        int lat;
        bit g1, g2;
        g1 = 0; g2 = 0; l1 = -1; l2 = -1; o1 = '0; o2 = '0; om1 = 0; om2 = 0;
        @(negedge clk);
        d8 = d; k8 = k; m8 = m; v8 = 1'b1; ordy8 = 1'b0;
        check_eq("xfer8_ready", {r1_irdy, r2_irdy}, 2'b11);
        @(posedge clk);
        #1 v8 = 1'b0; ordy8 = 1'b1;
        lat = 1;
        while (!(g1 && g2) && lat < 20) begin
            @(posedge clk);
            #1 lat++;
            if (r1_ov && !g1) begin g1 = 1; o1 = r1_od; om1 = r1_om; l1 = lat; end
            if (r2_ov && !g2) begin g2 = 1; o2 = r2_od; om2 = r2_om; l2 = lat; end
        end
        @(posedge clk);
        #1 ordy8 = 1'b0;
    endtask

    task automatic xfer3(input logic [31:0] d, input logic [31:0] k, input logic m,
                         output logic [31:0] o, output logic om, output int lat);
        int w;
        o = '0; om = 1'b0; lat = -1;
        @(negedge clk);
        d3 = d; k3 = k; m3 = m; v3 = 1'b1; ordy3 = 1'b0;
        w = 0;
        while (!ir3 && w < 50) begin @(negedge clk); w++; end
        check_eq("xfer3_ready", ir3, 1'b1);
        @(posedge clk);
        #1 v3 = 1'b0;
        lat = 1;
        while (!ov3 && lat < 50) begin
            @(posedge clk);
            #1 lat++;
        end
        o = od3; om = om3;
        ordy3 = 1'b1;
        @(posedge clk);
        #1 ordy3 = 1'b0;
    endtask

    initial begin
        logic [7:0]  o1, o2;
        logic        om1, om2, cm, pm;
        int          l1, l2, lat, w, na;
        logic [31:0] pd, pk, c, p, exp;
        int          acc[4];

        rst_n = 1'b0;
        v8 = 0; m8 = 0; ordy8 = 0; d8 = '0; k8 = '0;
        v3 = 0; m3 = 0; ordy3 = 0; d3 = '0; k3 = '0;
        #3;
        check_eq("rst_in_ready", ir3, 1'b0);
        check_eq("rst_out_valid", ov3, 1'b0);
        check_eq("rst_out_data", od3, 32'h0);
        check_eq("rst_out_mode", om3, 1'b0);
        check_eq("rst_busy", busy3, 1'b0);
        check_eq("rst_in_ready_r1", r1_irdy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_eq("rel_in_ready", ir3, 1'b1);

        // Single- and two-round vectors, key 00.
        xfer8(8'h00, 8'h00, 1'b0, o1, o2, om1, om2, l1, l2);
        check_eq("r1_enc00", o1, 8'h5A);
        check_eq("r2_enc00", o2, 8'h34);
        check_eq("r1_lat", l1, 2);
        check_eq("r2_lat", l2, 3);
        check_eq("r1_mode_enc", om1, 1'b0);
        xfer8(8'h01, 8'h00, 1'b0, o1, o2, om1, om2, l1, l2);
        check_eq("r1_enc01", o1, 8'h62);
        check_eq("r2_enc01", o2, 8'h75);
        xfer8(8'h34, 8'h00, 1'b1, o1, o2, om1, om2, l1, l2);
        check_eq("r1_dec34", o1, 8'h5B);
        check_eq("r2_dec34", o2, 8'h00);
        check_eq("r2_dec_lat", l2, 3);
        check_eq("r2_mode_dec", om2, 1'b1);

        for (int i = 0; i < 200; i++) begin
            pd = $urandom;
            pk = $urandom;
            xfer3(pd, pk, 1'b0, c, cm, lat);
            check_eq("rt_cipher", c, model_enc(pd, pk));
            check_eq("rt_enc_mode", cm, 1'b0);
            check_eq("rt_enc_lat", lat, 5);
            xfer3(c, pk, 1'b1, p, pm, lat);
            check_eq("rt_plain", p, pd);
            check_eq("rt_dec_mode", pm, 1'b1);
            check_eq("rt_dec_lat", lat, 5);
        end

        // Backpressure: hold the result for 10 cycles while a new block is offered.
        pd = 32'h0123_4567; pk = 32'h89AB_CDEF; exp = model_enc(pd, pk);
        @(negedge clk);
        d3 = pd; k3 = pk; m3 = 1'b0; v3 = 1'b1; ordy3 = 1'b0;
        @(posedge clk);
        #1 v3 = 1'b0;
        lat = 1;
        while (!ov3 && lat < 50) begin @(posedge clk); #1 lat++; end
        check_eq("bp_lat", lat, 5);
        d3 = ~pd; k3 = ~pk; m3 = 1'b1; v3 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp_data", od3, exp);
            check_eq("bp_valid", ov3, 1'b1);
            check_eq("bp_in_ready", ir3, 1'b0);
            check_eq("bp_mode", om3, 1'b0);
        end
        v3 = 1'b0; ordy3 = 1'b1;
        @(posedge clk);
        #1 ordy3 = 1'b0;
        check_eq("bp_valid_after", ov3, 1'b0);
        check_eq("bp_data_kept", od3, exp);
        check_eq("bp_idle", busy3, 1'b0);
        check_eq("bp_ready_after", ir3, 1'b1);

        // Reset during the third RUN cycle (counter = 2).
        @(negedge clk);
        d3 = 32'hDEAD_BEEF; k3 = 32'h0F0F_0F0F; m3 = 1'b0; v3 = 1'b1;
        @(posedge clk);
        #1 v3 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_eq("mr_out_valid", ov3, 1'b0);
        check_eq("mr_busy", busy3, 1'b0);
        check_eq("mr_in_ready", ir3, 1'b0);
        check_eq("mr_out_data", od3, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_eq("mr_ready_rel", ir3, 1'b1);
        xfer3(32'hCAFE_F00D, 32'h1357_2468, 1'b0, c, cm, lat);
        check_eq("mr_next_cipher", c, model_enc(32'hCAFE_F00D, 32'h1357_2468));
        check_eq("mr_next_lat", lat, 5);

        // Throughput with in_valid and out_ready held high.
        @(negedge clk);
        d3 = 32'h5555_AAAA; k3 = 32'h1234_5678; m3 = 1'b0; v3 = 1'b1; ordy3 = 1'b1;
        acc = '{default: 0};
        na = 0;
        for (int cyc = 0; cyc < 40 && na < 4; cyc++) begin
            if (ir3) begin acc[na] = cyc; na++; end
            @(negedge clk);
        end
        check_eq("tp_accepts", na, 4);
        for (int i = 0; i < 3; i++)
            check_eq("tp_spacing", acc[i+1] - acc[i], 6);
        v3 = 1'b0;
        w = 0;
        while (busy3 && w < 50) begin @(negedge clk); w++; end
        check_eq("tp_drain", busy3, 1'b0);
        ordy3 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cipher_round_engine.md
CIPHER_ROUND_ENGINE -- requirements
Module: cipher_round_engine

Interface
REQ-001 Parameter DATA_W SHALL be: DATA_W, default 32, block width in bits; multiple of 8, range 8..128.
REQ-002 Parameter ROUNDS SHALL be: ROUNDS, default 4, rounds per block; range 1..15.
REQ-003 Parameter ROT SHALL be: ROT, default 3, per-byte rotate amount; range 1..7.
REQ-004 Port SHALL be: clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port SHALL be: rst_n  input  1  reset; asynchronous, active-low.
REQ-006 Port SHALL be: in_valid  input  1  input block offered.
REQ-007 Port SHALL be: in_ready  output  1  engine can accept a block.
REQ-008 Port SHALL be: in_data  input  DATA_W  plaintext or ciphertext block.
REQ-009 Port SHALL be: in_mode  input  1  0 = encrypt, 1 = decrypt.
REQ-010 Port SHALL be: key  input  DATA_W  block key; sampled only at input handshake.
REQ-011 Port SHALL be: out_valid  output  1  result block available.
REQ-012 Port SHALL be: out_ready  input  1  consumer accepts the result.
REQ-013 Port SHALL be: out_data  output  DATA_W  result block.
REQ-014 Port SHALL be: out_mode  output  1  mode used for the current out_data.
REQ-015 Port SHALL be: busy  output  1  high in RUN and DONE.

Function
REQ-016 FSM states SHALL be IDLE, RUN and DONE. in_ready = 1 only in IDLE with rst_n high.
REQ-017 In IDLE, in_valid & in_ready SHALL latch in_data, key and in_mode, then move to RUN.
REQ-018 On entry to RUN, the round counter SHALL be 0 for encrypt and ROUNDS-1 for decrypt.
REQ-019 RUN SHALL apply exactly one round per cycle, for ROUNDS cycles, and then move to DONE.
REQ-020 Each round SHALL act on every byte b independently: d_b = data byte b, k_b = key byte b, r = round counter (8-bit).
REQ-021 Encrypt round SHALL compute d_b <= rotl8(d_b ^ k_b ^ r, ROT) + 8'h5A, modulo 256. The counter increments.
REQ-022 Decrypt round SHALL compute d_b <= rotr8(d_b - 8'h5A, ROT) ^ k_b ^ r, modulo 256. The counter decrements.
REQ-023 Decrypt of an encrypt result SHALL return the original block for identical key, ROUNDS and ROT.
REQ-024 out_valid SHALL rise exactly ROUNDS+1 clock edges after the accepting edge.
REQ-025 In DONE, out_valid SHALL be 1, and out_data and out_mode SHALL hold stable until out_valid & out_ready.
REQ-026 On the output handshake the FSM SHALL return to IDLE. out_data SHALL retain its last value and out_valid SHALL be 0.
REQ-027 Changes on in_data, key, in_mode or in_valid while busy SHALL have no effect.
REQ-028 out_ready asserted outside DONE SHALL be ignored. No simultaneous input and output handshake is possible.
REQ-029 Sustained throughput SHALL be one block per ROUNDS+2 cycles when out_ready is held high.
REQ-030 Byte 0 SHALL be bits [7:0]. The byte order of the result SHALL match the input.

Reset
REQ-031 rst_n low SHALL immediately force: FSM = IDLE, counter = 0, in_ready = 0, out_valid = 0, out_data = 0, out_mode = 0, busy = 0.
REQ-032 Reset mid-RUN or mid-DONE SHALL abandon the block with no output handshake. in_ready SHALL be 1 in the first cycle after rst_n rises.

Verification
REQ-033 Bench SHALL cover single round: DATA_W=8, ROUNDS=1, ROT=3, key 00, encrypt 00 -> 5A and encrypt 01 -> 62.
REQ-034 Bench SHALL cover two rounds: DATA_W=8, ROUNDS=2, key 00, encrypt 00 -> 34. Decrypt 34 -> 00, with out_valid exactly 3 edges after accept.
REQ-035 Bench SHALL cover round trip at defaults: 200 random in_data/key pairs, encrypt then decrypt -> original block, with out_mode matching each request.
REQ-036 Bench SHALL cover backpressure: out_ready held 0 for 10 cycles in DONE -> out_data stable, in_ready 0, and a new in_valid ignored.
REQ-037 Bench SHALL cover reset mid-RUN: rst_n pulsed low on round 2 -> out_valid 0 at once, in_ready 1 after release, and the next block correct.
REQ-038 Bench SHALL cover throughput: back-to-back blocks with out_ready = 1 -> accepts spaced exactly ROUNDS+2 cycles apart.
